packet_xor_stream: RTL and testbench
====================================

// Module: packet_xor_stream
// PURPOSE
// - Streaming, multi-beat successor to the combinational per-word packet XOR in the EC engine.
// - Each beat carries IN_PER_BEAT packets of W words; a per-packet mask selects which ones are XORed.
// - Beat results accumulate across a stripe of up to MAX_BEATS beats; one W-word parity packet
//   is emitted per stripe with valid/ready handshakes on both sides.
// - Sits between the packet fetch buffer and the parity writer in the engine datapath.
// PARAMETERS
// - IN_PER_BEAT    8   packets presented per input beat
// - W              4   words per packet (GF(2^W) bit-planes)
// - PACKET_LENGTH  2   bits per word
// - MAX_BEATS      16  max beats per stripe; counter width = $clog2(MAX_BEATS+1)
// PORTS
// - clk        in   1                              clock; all logic on rising edge
// - rst        in   1                              synchronous, active-high reset
// - in_valid   in   1                              input beat valid
// - in_ready   out  1                              block accepts beat when in_valid&&in_ready
// - in_packets in   [PACKET_LENGTH-1:0] [0:W-1][0:IN_PER_BEAT-1]  beat packets
// - in_mask    in   IN_PER_BEAT                    bit j=1: packet j joins the XOR
// - in_last    in   1                              final beat of stripe
// - out_valid  out  1                              parity packet valid
// - out_ready  in   1                              downstream accepts parity
// - out_xor    out  [PACKET_LENGTH-1:0] [0:W-1]    stripe parity
// - out_beats  out  $clog2(MAX_BEATS+1)            beats accumulated in this stripe
// - overflow   out  1                              sticky: beat MAX_BEATS accepted without in_last
// BEHAVIOUR
// - Reset: state=IDLE, accumulator=0, beat count=0, in_ready=0 during rst, then 1.
//   out_valid=0, out_xor=0, out_beats=0, overflow=0. Reset mid-stripe discards the partial stripe.
// - Beat XOR per word w: bx[w] = XOR over j of (in_mask[j] ? in_packets[w][j] : 0). Masks of 0 give 0.
// - FSM states:
//   - IDLE: on first accepted beat, acc<=bx, cnt<=1 -> ACCUM, or -> OUT if in_last.
//   - ACCUM: each accepted beat: acc<=acc^bx, cnt<=cnt+1; in_last -> OUT.
//   - OUT: out_valid=1; out_xor=acc and out_beats=cnt, stable while out_valid&&!out_ready.
//     On out_ready, acc<=0, cnt<=0 -> IDLE.
// - in_ready = (state!=OUT) && !rst. No beat is accepted in the cycle the output is taken.
//   The next stripe starts at the earliest one cycle later.
// - Latency: last beat accepted in cycle t -> out_valid in cycle t+1.
// - Overflow: an accepted beat that makes cnt==MAX_BEATS with in_last=0 is treated as last.
//   It sets overflow (cleared only by rst), moves to OUT, and out_beats=MAX_BEATS. The counter never wraps.
// - in_valid without in_ready: no state change; the source must hold data stable (AXI-style).
// - out_valid never drops without out_ready.
// CONFIGURATION
// - PKT_XOR_PIPE_EN defined:
//   - a register stage holds bx, its valid bit, and the last/overflow tag before accumulation;
//   - latency becomes t+2;
//   - in_ready is also deasserted while the staged beat is tagged last, so nothing follows a
//     stripe end until OUT is entered.
// - PKT_XOR_PIPE_EN undefined: bx feeds the accumulator combinationally, latency t+1 (above).
// - All visible ordering and handshake rules are identical in both builds.
// STRUCTURE
// - Shared package ec_accel_pkg:
//   - typedef pxs_state_e {IDLE, ACCUM, OUT};
//   - localparam function for the counter width;
//   - typedef word_t = logic [PACKET_LENGTH-1:0].
// - Sub-module packet_beat_xor: purely combinational masked XOR tree, one per word w, generated W times.
// - FSM, counter, accumulator, optional pipe stage and handshakes live in the top.
// TESTING
// - Single beat: IN_PER_BEAT=8, W=4, mask=8'h05, last=1, packets[w][0]=2'b01, packets[w][2]=2'b11,
//   others 2'b10 -> out_xor[w]=2'b10, out_beats=1, at t+1 (t+2 with PIPE_EN).
// - Three-beat stripe, masks 8'hFF, 8'h00, 8'h01, all data=2'b11 -> out_xor=2'b11
//   (8 words XOR to 0, beat 3 gives 11), out_beats=3.
// - Backpressure: hold out_ready=0 for 5 cycles -> out_valid, out_xor stable, in_ready=0.
//   Release -> next stripe accepted one cycle later.
// - Overflow: MAX_BEATS=16 beats, in_last never set -> OUT after beat 16, overflow=1, out_beats=16.
//   overflow persists until rst.
// - Reset mid-stripe after 2 beats -> all outputs 0. A new 1-beat stripe yields only its own XOR.
// - Random in_valid/out_ready throttling, 1000 stripes, vs reference model -> zero mismatches,
//   no beat loss or duplication.

Source files
------------

// File: rtl/ec_accel_pkg.sv
// Shared types and sizing for the EC accelerator packet XOR datapath.
// Default geometry: 8 packets per beat, 4 words per packet, 2-bit words, 16-beat stripes.
package ec_accel_pkg;

  localparam int PXS_IN_PER_BEAT   = 8;
  localparam int PXS_W             = 4;
  localparam int PXS_PACKET_LENGTH = 2;
  localparam int PXS_MAX_BEATS     = 16;

  typedef logic [PXS_PACKET_LENGTH-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } pxs_state_e;

  // Beat counter must be able to hold MAX_BEATS itself, not just MAX_BEATS-1.
  function automatic int pxs_cnt_width(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

  localparam int PXS_CNT_W = pxs_cnt_width(PXS_MAX_BEATS);

endpackage

// File: rtl/packet_beat_xor.sv
// Masked XOR of one word position across all packets of a beat.
// Purely combinational; an all-zero mask yields zero.
module packet_beat_xor
  import ec_accel_pkg::*;
#(
  parameter int IN_PER_BEAT = PXS_IN_PER_BEAT
) (
  input  word_t [0:IN_PER_BEAT-1] packets,
  input  logic  [IN_PER_BEAT-1:0] mask,
  output word_t                   word_xor
);

  always_comb begin
    word_xor = '0;
    for (int j = 0; j < IN_PER_BEAT; j++) begin
      if (mask[j]) begin
        word_xor = word_xor ^ packets[j];
      end
    end
  end

endmodule

// File: rtl/packet_xor_stream.sv
// Streaming stripe parity: XORs masked packets over up to MAX_BEATS beats, emits one parity packet.
// Define PKT_XOR_PIPE_EN to register the beat XOR before accumulation (one extra cycle of latency).
module packet_xor_stream
  import ec_accel_pkg::*;
#(
  parameter  int IN_PER_BEAT = PXS_IN_PER_BEAT,
  parameter  int W           = PXS_W,
  parameter  int MAX_BEATS   = PXS_MAX_BEATS,
  localparam int CNT_W       = pxs_cnt_width(MAX_BEATS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  word_t [0:W-1][0:IN_PER_BEAT-1]     in_packets,
  input  logic  [IN_PER_BEAT-1:0]            in_mask,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output word_t [0:W-1]                      out_xor,
  output logic  [CNT_W-1:0]                  out_beats,
  output logic                               overflow
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  pxs_state_e       state_q, state_d;
  word_t [0:W-1]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  word_t [0:W-1]    bx;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept, hit_max, beat_end, beat_ovf;

  // Beat presented to the accumulator, either straight from the input or from the stage.
  logic             acc_en, acc_end, acc_ovf;
  word_t [0:W-1]    acc_bx;

  for (genvar gi = 0; gi < W; gi++) begin : g_word
    packet_beat_xor #(
      .IN_PER_BEAT(IN_PER_BEAT)
    ) u_beat_xor (
      .packets  (in_packets[gi]),
      .mask     (in_mask),
      .word_xor (bx[gi])
    );
  end

  // The counter tracks accepted beats, so a stripe end is decided at accept time.
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign hit_max  = (cnt_inc == MAX_CNT);
  assign beat_end = in_last || hit_max;
  assign beat_ovf = hit_max && !in_last;
  assign accept   = in_valid && in_ready;

`ifdef PKT_XOR_PIPE_EN
  logic          stg_valid_q, stg_valid_d;
  logic          stg_last_q, stg_last_d;
  logic          stg_ovf_q, stg_ovf_d;
  word_t [0:W-1] stg_bx_q, stg_bx_d;

  // A staged stripe end blocks further beats until OUT is reached.
  assign in_ready = (state_q != OUT) && !(stg_valid_q && stg_last_q) && !rst;

  always_comb begin
    stg_valid_d = accept;
    stg_bx_d    = stg_bx_q;
    stg_last_d  = stg_last_q;
    stg_ovf_d   = stg_ovf_q;
    if (accept) begin
      stg_bx_d   = bx;
      stg_last_d = beat_end;
      stg_ovf_d  = beat_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid_q <= 1'b0;
      stg_last_q  <= 1'b0;
      stg_ovf_q   <= 1'b0;
      stg_bx_q    <= '0;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_last_q  <= stg_last_d;
      stg_ovf_q   <= stg_ovf_d;
      stg_bx_q    <= stg_bx_d;
    end
  end

  assign acc_en  = stg_valid_q;
  assign acc_bx  = stg_bx_q;
  assign acc_end = stg_last_q;
  assign acc_ovf = stg_ovf_q;
`else
  assign in_ready = (state_q != OUT) && !rst;

  assign acc_en  = accept;
  assign acc_bx  = bx;
  assign acc_end = beat_end;
  assign acc_ovf = beat_ovf;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_valid = 1'b0;
    out_xor   = '0;
    out_beats = '0;

    if (accept) begin
      cnt_d = cnt_inc;
    end

    case (state_q)
      IDLE: begin
        if (acc_en) begin
          acc_d   = acc_bx;
          state_d = acc_end ? OUT : ACCUM;
          ovf_d   = ovf_q | acc_ovf;
        end
      end
      ACCUM: begin
        if (acc_en) begin
          acc_d   = acc_q ^ acc_bx;
          state_d = acc_end ? OUT : ACCUM;
          ovf_d   = ovf_q | acc_ovf;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        out_xor   = acc_q;
        out_beats = cnt_q;
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign overflow = ovf_q;

endmodule

// File: tb/tb_packet_xor_stream.sv
// Bench for packet_xor_stream: vector table, directed corner sequences and a randomized
// 1000-stripe run against a queue reference. Define PKT_XOR_PIPE_EN to match the RTL build.
module tb_packet_xor_stream;
  import ec_accel_pkg::*;

  localparam int N    = PXS_IN_PER_BEAT;
  localparam int W    = PXS_W;
  localparam int MAXB = PXS_MAX_BEATS;
  localparam int CW   = PXS_CNT_W;
`ifdef PKT_XOR_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef word_t [0:W-1][0:N-1] beat_t;
  typedef word_t [0:W-1]        parity_t;
  typedef struct {
    logic [N-1:0]  mask;
    word_t [N-1:0] lanes;
    word_t         exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, in_last, out_valid, out_ready, overflow;
  beat_t         in_packets;
  logic [N-1:0]  in_mask;
  parity_t       out_xor;
  logic [CW-1:0] out_beats;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  packet_xor_stream dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_packets (in_packets),
    .in_mask    (in_mask),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_xor    (out_xor),
    .out_beats  (out_beats),
    .overflow   (overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference beat XOR straight from the masking rule.
  function automatic parity_t model_bx(input beat_t p, input logic [N-1:0] m);
    parity_t r = '0;
    for (int w = 0; w < W; w++)
      for (int j = 0; j < N; j++)
        if (m[j]) r[w] ^= p[w][j];
    return r;
  endfunction

  function automatic beat_t spread(input word_t [N-1:0] lanes);
    beat_t b;
    for (int w = 0; w < W; w++)
      for (int j = 0; j < N; j++)
        b[w][j] = lanes[j];
    return b;
  endfunction

  task automatic send_beat(input beat_t p, input logic [N-1:0] m, input logic l, input bit gaps);
    bit fire = 1'b0;
    int guard = 0;
    if (gaps) while ($urandom_range(0, 3) == 0) step();
    in_packets = p;
    in_mask    = m;
    in_last    = l;
    in_valid   = 1'b1;
    while (!fire && guard < 200) begin
      fire = in_ready;
      step();
      guard++;
    end
    in_valid = 1'b0;
    if (!fire) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: beat not accepted within 200 cycles");
    end
  endtask

  task automatic wait_out(input string name);
    int n = 1;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    chk(name, 32'(n), 32'(LAT));
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t    vecs [6];
    parity_t e, exp_p, racc;
    beat_t   b;
    logic [N-1:0] m;
    parity_t exp_x [$];
    int      exp_n [$];
    bit      prod_done, model_ovf;
    int      rn;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_mask = '0; in_packets = '0; out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_xor", 32'(out_xor), 32'd0);
    chk("rst_out_beats", 32'(out_beats), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    step();
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Single-beat stripes; same lane pattern in every word.
    vecs[0] = '{mask: 8'h05, lanes: 16'b10_10_10_10_10_11_10_01, exp: 2'b10};
    vecs[1] = '{mask: 8'h00, lanes: 16'hFFFF,                    exp: 2'b00};
    vecs[2] = '{mask: 8'hFF, lanes: 16'hFFFF,                    exp: 2'b00};
    vecs[3] = '{mask: 8'h80, lanes: 16'b01_11_11_11_11_11_11_11, exp: 2'b01};
    vecs[4] = '{mask: 8'h0F, lanes: 16'b00_00_00_00_11_10_01_01, exp: 2'b01};
    vecs[5] = '{mask: 8'hA8, lanes: 16'hAAAA,                    exp: 2'b10};
    for (int i = 0; i < 6; i++) begin
      send_beat(spread(vecs[i].lanes), vecs[i].mask, 1'b1, 1'b0);
      wait_out($sformatf("vec%0d_latency", i));
      for (int w = 0; w < W; w++) e[w] = vecs[i].exp;
      chk($sformatf("vec%0d_xor", i), 32'(out_xor), 32'(e));
      chk($sformatf("vec%0d_beats", i), 32'(out_beats), 32'd1);
      take_out();
    end

    // Three-beat stripe, then backpressure on its result.
    send_beat(spread(16'hFFFF), 8'hFF, 1'b0, 1'b0);
    send_beat(spread(16'hFFFF), 8'h00, 1'b0, 1'b0);
    send_beat(spread(16'hFFFF), 8'h01, 1'b1, 1'b0);
    wait_out("three_latency");
    chk("three_xor", 32'(out_xor), 32'hFF);
    chk("three_beats", 32'(out_beats), 32'd3);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_xor", 32'(out_xor), 32'hFF);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    take_out();
    chk("bp_released_valid", 32'(out_valid), 32'd0);
    chk("bp_released_in_ready", 32'(in_ready), 32'd1);

    // Overflow: MAXB beats without in_last.
    exp_p = '0;
    for (int i = 0; i < MAXB; i++) begin
      for (int w = 0; w < W; w++)
        for (int j = 0; j < N; j++)
          b[w][j] = word_t'(i + w * j);
      m = N'(i * 37 + 1);
      exp_p ^= model_bx(b, m);
      if (i == MAXB - 1) chk("ovf_not_yet", 32'(overflow), 32'd0);
      send_beat(b, m, 1'b0, 1'b0);
    end
    wait_out("ovf_latency");
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_beats", 32'(out_beats), 32'(MAXB));
    chk("ovf_xor", 32'(out_xor), 32'(exp_p));
    chk("ovf_in_ready", 32'(in_ready), 32'd0);
    take_out();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    send_beat(spread(16'h0001), 8'h01, 1'b1, 1'b0);
    wait_out("ovf_next_latency");
    take_out();
    chk("ovf_sticky2", 32'(overflow), 32'd1);

    // Reset mid-stripe discards the partial accumulation (01 here).
    send_beat(spread(16'hFFFF), 8'h01, 1'b0, 1'b0);
    send_beat(spread(16'h0002), 8'h01, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_xor", 32'(out_xor), 32'd0);
    chk("mid_rst_out_beats", 32'(out_beats), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    step();
    send_beat(spread(16'h0001), 8'h01, 1'b1, 1'b0);
    wait_out("post_rst_latency");
    chk("post_rst_xor", 32'(out_xor), 32'h55);
    chk("post_rst_beats", 32'(out_beats), 32'd1);
    take_out();

    // Random throttled stripes against the queue reference.
    prod_done = 1'b0;
    model_ovf = 1'b0;
    racc = '0;
    rn = 0;
    fork
      begin : producer
        int len;
        logic l;
        beat_t pb;
        logic [N-1:0] pm;
        for (int s = 0; s < 1000; s++) begin
          len = ($urandom_range(0, 19) == 0) ? int'($urandom_range(15, 20)) : int'($urandom_range(1, 5));
          for (int i = 0; i < len; i++) begin
            for (int w = 0; w < W; w++)
              for (int j = 0; j < N; j++)
                pb[w][j] = word_t'($urandom);
            pm = N'($urandom);
            l = (i == len - 1);
            racc ^= model_bx(pb, pm);
            rn++;
            if (l || rn == MAXB) begin
              if (!l) model_ovf = 1'b1;
              exp_x.push_back(racc);
              exp_n.push_back(rn);
              racc = '0;
              rn = 0;
            end
            send_beat(pb, pm, l, 1'b1);
          end
        end
        prod_done = 1'b1;
      end
      begin : consumer
        int cyc;
        bit held;
        parity_t hx;
        cyc = 0;
        held = 1'b0;
        while ((!prod_done || exp_x.size() != 0) && cyc < 60000) begin
          out_ready = ($urandom_range(0, 9) < 6);
          if (held) begin
            chk("rnd_hold_valid", 32'(out_valid), 32'd1);
            chk("rnd_hold_xor", 32'(out_xor), 32'(hx));
          end
          held = 1'b0;
          if (out_valid) begin
            if (out_ready) begin
              if (exp_x.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rnd_extra: unexpected parity 0x%0h", out_xor);
              end else begin
                chk("rnd_xor", 32'(out_xor), 32'(exp_x.pop_front()));
                chk("rnd_beats", 32'(out_beats), 32'(exp_n.pop_front()));
              end
            end else begin
              held = 1'b1;
              hx = out_xor;
            end
          end
          step();
          cyc++;
        end
        out_ready = 1'b0;
        if (cyc >= 60000) begin
          checks++;
          errors++;
          $display("FAIL rnd_timeout: %0d parity packets still expected", exp_x.size());
        end
      end
    join
    chk("rnd_leftover", 32'(exp_x.size()), 32'd0);
    chk("rnd_overflow", 32'(overflow), 32'(model_ovf));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
